// File: rtl/pacman_map_writer.sv
// pacman_map_writer: tile-map RAM write engine for pacman moves.
// On each request it reads the target tile, reports its code on collision_type,
// and on a legal move it erases pacman from the current tile, draws it on the
// next tile, and counts eaten pills/power pellets.
//
// Ports:
//   CLOCK_50        system clock
//   reset_n         asynchronous active-low reset
//   ready           request from the location controller (curr/next valid while high)
//   curr_pacman_*   current tile
//   next_pacman_*   requested tile
//   done            one-cycle completion pulse
//   collision_type  tile code found at the requested tile
//   pill_count      saturating count of pills + power pellets eaten
//   pill_pulse      one-cycle pulse when something edible is eaten
//   ram_addr/ram_wdata/ram_we/ram_rdata  single-port synchronous tile RAM
module pacman_map_writer #(
  parameter int unsigned MAP_W  = 40,
  parameter int unsigned MAP_H  = 30,
  parameter int unsigned PILL_W = 33
) (
  input  logic              CLOCK_50,
  input  logic              reset_n,
  input  logic              ready,
  input  logic [5:0]        curr_pacman_x,
  input  logic [4:0]        curr_pacman_y,
  input  logic [5:0]        next_pacman_x,
  input  logic [4:0]        next_pacman_y,
  output logic              done,
  output logic [3:0]        collision_type,
  output logic [PILL_W-1:0] pill_count,
  output logic              pill_pulse,
  output logic [10:0]       ram_addr,
  output logic [3:0]        ram_wdata,
  output logic              ram_we,
  input  logic [3:0]        ram_rdata
);

  localparam logic [3:0] TileEmpty  = 4'h0;
  localparam logic [3:0] TileWall   = 4'h1;
  localparam logic [3:0] TilePill   = 4'h2;
  localparam logic [3:0] TilePacman = 4'h3;
  localparam logic [3:0] TilePower  = 4'h4;

  typedef enum logic [2:0] {
    StIdle, StRead, StEval, StErase, StDraw, StDone, StRearm
  } state_e;

  state_e              r_state, w_state_d;
  logic [5:0]          r_cur_x, r_nxt_x;
  logic [4:0]          r_cur_y, r_nxt_y;
  logic [3:0]          r_collision;
  logic [PILL_W-1:0]   r_pill_count;
  logic                r_done;
  logic                r_armed;

  logic                w_oob;
  logic                w_null_move;
  logic [3:0]          w_tile;
  logic                w_eaten;
  logic                w_done_state;

  // Coordinates past the map edge (including 0-1 wrapping to 63/31) act as walls.
  assign w_oob       = (32'(r_nxt_x) >= MAP_W) || (32'(r_nxt_y) >= MAP_H);
  assign w_null_move = ({r_nxt_y, r_nxt_x} == {r_cur_y, r_cur_x});
  assign w_eaten     = (r_collision == TilePill) || (r_collision == TilePower);

  always_comb begin
    w_tile = TileEmpty;
    if (w_oob) begin
      w_tile = TileWall;
    end else begin
      case (ram_rdata)
        TileWall, TilePill, TilePacman, TilePower: w_tile = ram_rdata;
        default:                                   w_tile = TileEmpty;
      endcase
    end
  end

  // State register
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) r_state <= StIdle;
    else          r_state <= w_state_d;
  end

  // Next-state logic
  always_comb begin
    w_state_d = r_state;
    case (r_state)
      StIdle:  if (ready && r_armed) w_state_d = StRead;
      StRead:  w_state_d = StEval;
      StEval:  w_state_d = ((w_tile == TileWall) || w_null_move) ? StDone : StErase;
      StErase: w_state_d = StDraw;
      StDraw:  w_state_d = StDone;
      StDone:  w_state_d = StRearm;
      StRearm: if (!ready) w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  // Output logic: RAM port is driven directly from the state so the read
  // address lines up with rdata arriving in EVAL.
  always_comb begin
    ram_addr     = '0;
    ram_wdata    = TileEmpty;
    ram_we       = 1'b0;
    pill_pulse   = 1'b0;
    w_done_state = 1'b0;
    case (r_state)
      StRead:  ram_addr = {r_nxt_y, r_nxt_x};
      StErase: begin
        ram_addr   = {r_cur_y, r_cur_x};
        ram_wdata  = TileEmpty;
        ram_we     = 1'b1;
        pill_pulse = w_eaten;
      end
      StDraw: begin
        ram_addr  = {r_nxt_y, r_nxt_x};
        ram_wdata = TilePacman;
        ram_we    = 1'b1;
      end
      StDone:  w_done_state = 1'b1;
      default: ;
    endcase
  end

  // Datapath registers. done is registered, so the pulse follows the DONE
  // state by one cycle, after the last write has landed in the RAM.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      r_cur_x      <= '0;
      r_cur_y      <= '0;
      r_nxt_x      <= '0;
      r_nxt_y      <= '0;
      r_collision  <= TileEmpty;
      r_pill_count <= '0;
      r_done       <= 1'b0;
      r_armed      <= 1'b1;
    end else begin
      r_done <= w_done_state;
      if (r_state == StIdle && ready && r_armed) begin
        r_cur_x     <= curr_pacman_x;
        r_cur_y     <= curr_pacman_y;
        r_nxt_x     <= next_pacman_x;
        r_nxt_y     <= next_pacman_y;
        r_collision <= TileEmpty;
      end
      if (r_state == StEval) r_collision <= w_tile;
      if (r_state == StErase && w_eaten && (r_pill_count != '1)) begin
        r_pill_count <= r_pill_count + PILL_W'(1);
      end
      // armed stays low until ready drops, so a held ready cannot retrigger.
      if (r_state == StDone)             r_armed <= 1'b0;
      else if (r_state == StRearm && !ready) r_armed <= 1'b1;
    end
  end

  assign done           = r_done;
  assign collision_type = r_collision;
  assign pill_count     = r_pill_count;

endmodule

// File: tb/tb_pacman_map_writer.sv
// Directed testbench for pacman_map_writer with a behavioural synchronous RAM.
module tb_pacman_map_writer;

  localparam logic [3:0] TEmpty  = 4'h0;
  localparam logic [3:0] TWall   = 4'h1;
  localparam logic [3:0] TPill   = 4'h2;
  localparam logic [3:0] TPacman = 4'h3;
  localparam logic [3:0] TPower  = 4'h4;

  logic        CLOCK_50;
  logic        reset_n;
  logic        ready;
  logic [5:0]  curr_pacman_x, next_pacman_x;
  logic [4:0]  curr_pacman_y, next_pacman_y;
  logic        done;
  logic [3:0]  collision_type;
  logic [32:0] pill_count;
  logic        pill_pulse;
  logic [10:0] ram_addr;
  logic [3:0]  ram_wdata;
  logic        ram_we;
  logic [3:0]  ram_rdata;

  logic [3:0]  mem [0:2047] = '{default: 4'h0};
  logic        pk_en;
  logic [10:0] pk_addr;
  logic [3:0]  pk_data;

  int n_checks = 0;
  int n_fail   = 0;
  int n_we     = 0;
  int n_done   = 0;
  int n_pp     = 0;
  int n_pp_erase = 0;

  pacman_map_writer dut (
    .CLOCK_50       (CLOCK_50),
    .reset_n        (reset_n),
    .ready          (ready),
    .curr_pacman_x  (curr_pacman_x),
    .curr_pacman_y  (curr_pacman_y),
    .next_pacman_x  (next_pacman_x),
    .next_pacman_y  (next_pacman_y),
    .done           (done),
    .collision_type (collision_type),
    .pill_count     (pill_count),
    .pill_pulse     (pill_pulse),
    .ram_addr       (ram_addr),
    .ram_wdata      (ram_wdata),
    .ram_we         (ram_we),
    .ram_rdata      (ram_rdata)
  );

  initial CLOCK_50 = 1'b0;
  always #10 CLOCK_50 = ~CLOCK_50;

  // Tile RAM: one synchronous port, plus a bench-side preload path.
  always @(posedge CLOCK_50) begin
    if (pk_en)       mem[pk_addr] <= pk_data;
    else if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  always @(posedge CLOCK_50) begin
    if (ram_we)     n_we   = n_we + 1;
    if (done)       n_done = n_done + 1;
    if (pill_pulse) n_pp   = n_pp + 1;
    if (pill_pulse && ram_we && ram_wdata == TEmpty) n_pp_erase = n_pp_erase + 1;
  end

  function automatic logic [10:0] a(input logic [5:0] x, input logic [4:0] y);
    return {y, x};
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic set_tile(input logic [5:0] x, input logic [4:0] y, input logic [3:0] t);
    pk_en = 1'b1; pk_addr = a(x, y); pk_data = t;
    tick;
    pk_en = 1'b0;
  endtask

  // One full transaction; next inputs are scrambled after capture to show they are ignored.
  task automatic move(input string tag, input logic [5:0] cx, input logic [4:0] cy,
                      input logic [5:0] nx, input logic [4:0] ny, input int exp_lat,
                      input logic [3:0] exp_ct, input int exp_wr, input int exp_pc,
                      input int exp_pp);
    int w0, p0, e0, lat;
    logic seen;
    w0 = n_we; p0 = n_pp; e0 = n_pp_erase; lat = 0; seen = 1'b0;
    curr_pacman_x = cx; curr_pacman_y = cy;
    next_pacman_x = nx; next_pacman_y = ny;
    ready = 1'b1;
    while (!seen && lat < 20) begin
      tick;
      lat++;
      if (lat == 1) begin
        next_pacman_x = ~nx; next_pacman_y = ~ny;
      end
      seen = done;
    end
    check_eq({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    ready = 1'b0;
    tick;
    tick;
    check_eq({tag, "_collision"}, 64'(collision_type), 64'(exp_ct));
    check_eq({tag, "_writes"}, 64'(n_we - w0), 64'(exp_wr));
    check_eq({tag, "_pill_count"}, 64'(pill_count), 64'(exp_pc));
    check_eq({tag, "_pill_pulses"}, 64'(n_pp - p0), 64'(exp_pp));
    check_eq({tag, "_pulse_at_erase"}, 64'(n_pp_erase - e0), 64'(exp_pp));
    if (exp_wr == 2) begin
      check_eq({tag, "_drawn"}, 64'(mem[a(nx, ny)]), 64'(TPacman));
      check_eq({tag, "_erased"}, 64'(mem[a(cx, cy)]), 64'(TEmpty));
    end
  endtask

  initial begin
    int d0, w0;
    reset_n = 1'b0; ready = 1'b0; pk_en = 1'b0; pk_addr = '0; pk_data = '0;
    curr_pacman_x = '0; curr_pacman_y = '0; next_pacman_x = '0; next_pacman_y = '0;
    repeat (3) tick;
    check_eq("rst_done", 64'(done), 64'd0);
    check_eq("rst_we", 64'(ram_we), 64'd0);
    check_eq("rst_addr", 64'(ram_addr), 64'd0);
    check_eq("rst_wdata", 64'(ram_wdata), 64'd0);
    check_eq("rst_collision", 64'(collision_type), 64'd0);
    check_eq("rst_pill_count", 64'(pill_count), 64'd0);
    reset_n = 1'b1;
    tick;

    // Legal move, cycle by cycle
    set_tile(20, 19, TEmpty);
    set_tile(20, 20, TPacman);
    w0 = n_we;
    curr_pacman_x = 20; curr_pacman_y = 20; next_pacman_x = 20; next_pacman_y = 19;
    ready = 1'b1;
    tick;
    check_eq("t1_read_addr", 64'(ram_addr), 64'(a(20, 19)));
    check_eq("t1_read_we", 64'(ram_we), 64'd0);
    tick;
    check_eq("t1_eval_we", 64'(ram_we), 64'd0);
    tick;
    check_eq("t1_erase_we", 64'(ram_we), 64'd1);
    check_eq("t1_erase_addr", 64'(ram_addr), 64'(a(20, 20)));
    check_eq("t1_erase_wdata", 64'(ram_wdata), 64'(TEmpty));
    tick;
    check_eq("t1_draw_we", 64'(ram_we), 64'd1);
    check_eq("t1_draw_addr", 64'(ram_addr), 64'(a(20, 19)));
    check_eq("t1_draw_wdata", 64'(ram_wdata), 64'(TPacman));
    tick;
    check_eq("t1_done_early", 64'(done), 64'd0);
    tick;
    check_eq("t1_done", 64'(done), 64'd1);
    ready = 1'b0;
    tick;
    check_eq("t1_done_one_cycle", 64'(done), 64'd0);
    tick;
    check_eq("t1_collision", 64'(collision_type), 64'(TEmpty));
    check_eq("t1_pill_count", 64'(pill_count), 64'd0);
    check_eq("t1_writes", 64'(n_we - w0), 64'd2);
    check_eq("t1_mem_next", 64'(mem[a(20, 19)]), 64'(TPacman));
    check_eq("t1_mem_curr", 64'(mem[a(20, 20)]), 64'(TEmpty));

    // Pill then power pellet
    set_tile(20, 18, TPill);
    move("t2_pill", 20, 19, 20, 18, 6, TPill, 2, 1, 1);
    set_tile(21, 18, TPower);
    move("t2_power", 20, 18, 21, 18, 6, TPower, 2, 2, 1);

    // Wall, bounds and null move
    set_tile(22, 18, TWall);
    move("t3_wall", 21, 18, 22, 18, 4, TWall, 0, 2, 0);
    set_tile(63, 5, TEmpty);
    move("t4_wrap_x", 0, 5, 63, 5, 4, TWall, 0, 2, 0);
    move("t4_x40", 0, 5, 40, 5, 4, TWall, 0, 2, 0);
    move("t4_y30", 0, 5, 0, 30, 4, TWall, 0, 2, 0);
    move("t4_null", 21, 18, 21, 18, 4, TPacman, 0, 2, 0);

    // Unknown tile code behaves as empty
    set_tile(21, 17, 4'h9);
    move("t4_unknown", 21, 18, 21, 17, 6, TEmpty, 2, 2, 0);

    // Handshake hold: ready stays high well past done
    set_tile(21, 16, TPill);
    d0 = n_done; w0 = n_we;
    curr_pacman_x = 21; curr_pacman_y = 17; next_pacman_x = 21; next_pacman_y = 16;
    ready = 1'b1;
    repeat (16) tick;
    check_eq("t5_one_done", 64'(n_done - d0), 64'd1);
    check_eq("t5_writes", 64'(n_we - w0), 64'd2);
    check_eq("t5_pill_count", 64'(pill_count), 64'd3);
    ready = 1'b0;
    tick;
    move("t5_second", 21, 16, 21, 15, 6, TEmpty, 2, 3, 0);

    // Reset during DRAW
    curr_pacman_x = 21; curr_pacman_y = 15; next_pacman_x = 21; next_pacman_y = 14;
    ready = 1'b1;
    repeat (4) tick;
    check_eq("t6_in_draw", 64'(ram_we), 64'd1);
    reset_n = 1'b0;
    #1;
    check_eq("t6_rst_we", 64'(ram_we), 64'd0);
    check_eq("t6_rst_done", 64'(done), 64'd0);
    check_eq("t6_rst_pill_count", 64'(pill_count), 64'd0);
    check_eq("t6_rst_collision", 64'(collision_type), 64'd0);
    ready = 1'b0;
    tick;
    check_eq("t6_no_draw", 64'(mem[a(21, 14)]), 64'(TEmpty));
    reset_n = 1'b1;
    tick;
    move("t6_after_reset", 21, 15, 21, 14, 6, TEmpty, 2, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
